// File: rtl/sample_mac_accum.sv
// ---------------------------------------------------------------------------
// sample_mac_accum
//
// Consumer of the ce-gated sample multiplier. Tracks issued multiplies through
// the multiplier latency with a {valid, last} delay line, accumulates one
// product stream per vector on top of a bias, then scales, saturates and holds
// the result in a single-entry valid/ready output register. The block owns
// the multiplier clock enable, so a stalled result freezes the whole multiply
// pipeline together with the delay line.
//
// Optional build macro: SAMPLE_MAC_RELU_EN
//   defined   : negative scaled results become 0 before saturation; only
//               positive saturation sets res_ovf.
//   undefined : plain signed scale + saturate.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   issue_valid  in   operand pair presented to the multiplier this cycle
//   issue_last   in   qualifies issue_valid, last element of the vector
//   issue_ready  out  upstream may issue (same as mul_ce)
//   mul_ce       out  multiplier clock enable
//   prod         in   signed multiplier output, PROD_WIDTH bits
//   bias         in   signed bias, ACC_WIDTH bits, used by the first product
//   res_data     out  signed scaled/saturated result, OUT_WIDTH bits
//   res_ovf      out  res_data was saturated
//   res_valid    out  result held for the consumer
//   res_ready    in   consumer accepts the result
//   busy         out  vector in flight or result held
// ---------------------------------------------------------------------------
module sample_mac_accum #(
    parameter int PROD_WIDTH  = 11,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_WIDTH   = 16,
    parameter int MUL_LATENCY = 2,   // must be 1 or more
    parameter int FRAC_SHIFT  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_valid,
    input  logic                         issue_last,
    output logic                         issue_ready,
    output logic                         mul_ce,
    input  logic signed [PROD_WIDTH-1:0] prod,
    input  logic signed [ACC_WIDTH-1:0]  bias,
    output logic signed [OUT_WIDTH-1:0]  res_data,
    output logic                         res_ovf,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,   // no partial sum held
        ST_ACC  = 1'b1    // partial sum in acc_q
    } state_t;

    // Saturation bounds expressed at accumulator width so the comparison is
    // done on the full shifted value.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    state_t                       state_q, state_d;
    logic [MUL_LATENCY-1:0]       dl_valid_q, dl_valid_d;
    logic [MUL_LATENCY-1:0]       dl_last_q,  dl_last_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         res_valid_q, res_valid_d;
    logic signed [OUT_WIDTH-1:0]  res_data_q, res_data_d;
    logic                         res_ovf_q, res_ovf_d;

    logic                         accept;
    logic                         accept_last;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_base;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [ACC_WIDTH-1:0]  scaled;
    logic signed [OUT_WIDTH-1:0]  sat_data;
    logic                         sat_ovf;

    // -----------------------------------------------------------------------
    // Pipeline enable: only a held, unaccepted result stalls the pipe.
    // -----------------------------------------------------------------------
    assign mul_ce      = !res_valid_q || res_ready;
    assign issue_ready = mul_ce;

    // -----------------------------------------------------------------------
    // {valid, last} delay line mirroring the multiplier registers. The tail
    // stage lines up with prod; both shift and freeze on the same enable.
    // -----------------------------------------------------------------------
    assign dl_valid_d[0] = issue_valid;
    assign dl_last_d[0]  = issue_valid & issue_last;

    generate
        for (genvar gi = 1; gi < MUL_LATENCY; gi++) begin : g_dline
            assign dl_valid_d[gi] = dl_valid_q[gi-1];
            assign dl_last_d[gi]  = dl_last_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_valid_q <= '0;
            dl_last_q  <= '0;
        end else if (mul_ce) begin
            dl_valid_q <= dl_valid_d;
            dl_last_q  <= dl_last_d;
        end
    end

    assign accept      = dl_valid_q[MUL_LATENCY-1] && mul_ce;
    assign accept_last = accept && dl_last_q[MUL_LATENCY-1];

    // -----------------------------------------------------------------------
    // Datapath: the first product of a vector starts from the bias, later
    // products add onto the partial sum. Wraps modulo 2^ACC_WIDTH.
    // -----------------------------------------------------------------------
    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign acc_base = (state_q == ST_ACC) ? acc_q : bias;
    assign acc_sum  = acc_base + prod_ext;

    always_comb begin
        scaled   = acc_sum >>> FRAC_SHIFT;
        sat_data = '0;
        sat_ovf  = 1'b0;
`ifdef SAMPLE_MAC_RELU_EN
        // Rectify before the clamp so the zero floor never counts as overflow.
        if (scaled < 0) begin
            scaled = '0;
        end
`endif
        if (scaled > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_WIDTH-1:0];
            sat_ovf  = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sat_data = SAT_MIN[OUT_WIDTH-1:0];
            sat_ovf  = 1'b1;
        end else begin
            sat_data = scaled[OUT_WIDTH-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Accumulation FSM, next-state and output register logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;

        if (accept) begin
            if (dl_last_q[MUL_LATENCY-1]) begin
                state_d = ST_IDLE;
                acc_d   = '0;
            end else begin
                state_d = ST_ACC;
                acc_d   = acc_sum;
            end
        end

        // A last accept can only occur while mul_ce is high, i.e. when the
        // output register is empty or being drained this very edge, so the
        // new result may overwrite without losing anything.
        if (accept_last) begin
            res_valid_d = 1'b1;
            res_data_d  = sat_data;
            res_ovf_d   = sat_ovf;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_ovf   = res_ovf_q;
    assign busy      = (state_q == ST_ACC) || (|dl_valid_q) || res_valid_q;

endmodule

// File: tb/tb_sample_mac_accum.sv
// ---------------------------------------------------------------------------
// Testbench for sample_mac_accum. Contains a stand-in for the ce-gated
// multiplier (operands are already products; bias travels alongside them so
// it lines up with each vector), a table of directed vectors, hand-written
// backpressure / reset / back-to-back sequences and a randomized phase
// checked against an arithmetic reference of the accumulate-scale-saturate.
// ---------------------------------------------------------------------------
module tb_sample_mac_accum;

    localparam int PW  = 11;
    localparam int AW  = 24;
    localparam int OW  = 16;
    localparam int LAT = 2;
    localparam int FS  = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 issue_valid;
    logic                 issue_last;
    logic                 issue_ready;
    logic                 mul_ce;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] bias;
    logic signed [OW-1:0] res_data;
    logic                 res_ovf;
    logic                 res_valid;
    logic                 res_ready;
    logic                 busy;

    sample_mac_accum #(
        .PROD_WIDTH (PW),
        .ACC_WIDTH  (AW),
        .OUT_WIDTH  (OW),
        .MUL_LATENCY(LAT),
        .FRAC_SHIFT (FS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_last (issue_last),
        .issue_ready(issue_ready),
        .mul_ce     (mul_ce),
        .prod       (prod),
        .bias       (bias),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- multiplier stand-in (no reset, ce-gated) -------------
    logic signed [PW-1:0] prod_in;
    logic signed [AW-1:0] bias_in;
    logic signed [PW-1:0] m_q [LAT];
    logic signed [AW-1:0] b_q [LAT];

    always @(posedge clk) begin
        if (mul_ce) begin
            m_q[0] <= prod_in;
            b_q[0] <= bias_in;
            for (int i = 1; i < LAT; i++) begin
                m_q[i] <= m_q[i-1];
                b_q[i] <= b_q[i-1];
            end
        end
    end
    assign prod = m_q[LAT-1];
    assign bias = b_q[LAT-1];

    // ---------------- bookkeeping ------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int stall_cnt = 0;
    int hs_cnt  = 0;
    bit mon_en  = 1'b0;
    bit rand_ready = 1'b0;
    int exp_d_q[$];
    bit exp_o_q[$];
    int hs_cyc[$];
    int last_cyc[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: bias plus all products in ACC_WIDTH two's complement,
    // floor-divided by 2^FS, optionally rectified, then clamped.
    function automatic void ref_result(input int b, input int ps[$],
                                       output int d, output bit o);
        longint modv = longint'(1) << AW;
        longint total = b;
        longint s;
        longint maxv = (longint'(1) << (OW-1)) - 1;
        longint minv = -(longint'(1) << (OW-1));
        foreach (ps[k]) total += ps[k];
        total = ((total % modv) + modv) % modv;
        if (total >= modv / 2) total -= modv;
        if (total >= 0) s = total / (1 << FS);
        else            s = -((-total + (1 << FS) - 1) / (1 << FS));
`ifdef SAMPLE_MAC_RELU_EN
        if (s < 0) s = 0;
`endif
        o = 1'b0;
        if (s > maxv) begin s = maxv; o = 1'b1; end
        else if (s < minv) begin s = minv; o = 1'b1; end
        d = int'(s);
    endfunction

    // ---------------- monitor: sampled 1 time unit before each posedge -----
    always @(negedge clk) begin
        #4;
        cyc++;
        if (mon_en) begin
            check("issue_ready_eq_mul_ce", issue_ready, mul_ce);
            if (res_valid) begin
                if (exp_d_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0d expected no result (cycle %0d)",
                             res_data, cyc);
                end else begin
                    check("res_data", $signed(res_data), exp_d_q[0]);
                    check("res_ovf", res_ovf, exp_o_q[0]);
                end
                if (res_ready) begin
                    hs_cnt++;
                    hs_cyc.push_back(cyc);
                    if (exp_d_q.size() != 0) begin
                        void'(exp_d_q.pop_front());
                        void'(exp_o_q.pop_front());
                    end
                end
            end
        end
    end

    // random consumer backpressure
    always @(negedge clk) begin
        if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic issue_elem(input int p, input int b, input bit last);
        int w;
        @(negedge clk);
        issue_valid = 1'b1;
        issue_last  = last;
        prod_in     = PW'(p);
        bias_in     = AW'(b);
        #1;
        w = 0;
        while (!mul_ce) begin
            stall_cnt++;
            w++;
            if (w > 500) begin
                n_tests++;
                n_fail++;
                $display("FAIL issue_wait: got mul_ce=0 for %0d cycles expected 1", w);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $fatal(1, "issue wait expired");
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        if (last) last_cyc.push_back(cyc);
    endtask

    task automatic issue_vec(input int b, input int ps[$]);
        foreach (ps[k]) issue_elem(ps[k], b, k == ps.size() - 1);
    endtask

    task automatic go_idle();
        @(negedge clk);
        issue_valid = 1'b0;
        issue_last  = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            #2;
            if (exp_d_q.size() == 0 && !busy) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain: got %0d results pending, busy=%0d expected 0 pending, busy=0",
                     exp_d_q.size(), busy);
            exp_d_q.delete();
            exp_o_q.delete();
        end
    endtask

    // ---------------- directed table ---------------------------------------
    typedef struct {
        int n;
        int b;
        int p[4];
        int exp_d;
        bit exp_o;
    } vec_t;

    vec_t tbl[9];

    initial begin : main
        int ps[$];
        int d;
        bit o;
        int h0;

        // hard watchdog
        fork
            begin
                #2000000;
                $display("FAIL watchdog: got no finish expected finish before timeout");
                $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
                $fatal(1, "watchdog");
            end
        join_none

        tbl[0] = '{3, 16, '{32, -16, 64, 0}, 6, 1'b0};
        tbl[1] = '{1, 1048576, '{0, 0, 0, 0}, 32767, 1'b1};
`ifdef SAMPLE_MAC_RELU_EN
        tbl[2] = '{1, -1048576, '{0, 0, 0, 0}, 0, 1'b0};
        tbl[3] = '{1, -48, '{16, 0, 0, 0}, 0, 1'b0};
        tbl[6] = '{2, -5, '{1, 1, 0, 0}, 0, 1'b0};
        tbl[7] = '{1, 8388607, '{1, 0, 0, 0}, 0, 1'b0};
`else
        tbl[2] = '{1, -1048576, '{0, 0, 0, 0}, -32768, 1'b1};
        tbl[3] = '{1, -48, '{16, 0, 0, 0}, -2, 1'b0};
        tbl[6] = '{2, -5, '{1, 1, 0, 0}, -1, 1'b0};
        tbl[7] = '{1, 8388607, '{1, 0, 0, 0}, -32768, 1'b1};
`endif
        tbl[4] = '{1, 0, '{160, 0, 0, 0}, 10, 1'b0};
        tbl[5] = '{4, 100, '{1000, -200, 300, -50}, 71, 1'b0};
        tbl[8] = '{1, -8388608, '{-1, 0, 0, 0}, 32767, 1'b1};

        reset       = 1'b0;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        prod_in     = '0;
        bias_in     = '0;
        res_ready   = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", $signed(res_data), 0);
        check("rst_res_ovf", res_ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_ce", mul_ce, 1);
        check("rst_issue_ready", issue_ready, 1);
        reset  = 1'b1;
        mon_en = 1'b1;
        res_ready = 1'b1;

        // ---- table vectors with latency check ----
        for (int t = 0; t < 9; t++) begin
            ps.delete();
            for (int k = 0; k < tbl[t].n; k++) ps.push_back(tbl[t].p[k]);
            exp_d_q.push_back(tbl[t].exp_d);
            exp_o_q.push_back(tbl[t].exp_o);
            issue_vec(tbl[t].b, ps);
            go_idle();                       // cycle after edge t
            check("lat_valid_t0", res_valid, 0);
            check("lat_busy", busy, 1);
            @(negedge clk);                  // cycle after edge t+1
            check("lat_valid_t1", res_valid, 0);
            @(negedge clk);                  // cycle after edge t+2
            check("lat_valid_t2", res_valid, 1);
            wait_drain();
        end

        // ---- backpressure: result 6 held while a 4-vector issues ----
        res_ready = 1'b0;
        exp_d_q.push_back(6);
        exp_o_q.push_back(1'b0);
        exp_d_q.push_back(96);
        exp_o_q.push_back(1'b0);
        stall_cnt = 0;
        fork
            begin
                ps = '{32, -16, 64};
                issue_vec(16, ps);
                issue_elem(100, 1000, 1'b0);
                issue_elem(200, 1000, 1'b0);
                issue_elem(-50, 1000, 1'b0);
                issue_elem(300, 1000, 1'b1);
                go_idle();
            end
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    if (res_valid) seen = 1'b1;
                end
                check("bp_result_seen", seen, 1);
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    check("bp_mul_ce", mul_ce, 0);
                    check("bp_issue_ready", issue_ready, 0);
                    check("bp_busy", busy, 1);
                end
                @(negedge clk);
                res_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_stalled", stall_cnt > 0, 1);

        // ---- reset with two products in flight and acc=500 ----
        issue_elem(100, 400, 1'b0);
        issue_elem(200, 400, 1'b0);
        issue_elem(300, 400, 1'b0);
        @(negedge clk);
        issue_valid = 1'b0;
        mon_en = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", res_valid, 0);
        reset  = 1'b1;
        mon_en = 1'b1;
        h0 = hs_cnt;
        exp_d_q.push_back(10);
        exp_o_q.push_back(1'b0);
        issue_elem(160, 0, 1'b1);
        go_idle();
        wait_drain();
        repeat (5) @(negedge clk);
        check("mid_rst_one_result", hs_cnt - h0, 1);

        // ---- back-to-back vectors, no bubbles ----
        stall_cnt = 0;
        hs_cyc.delete();
        last_cyc.delete();
        exp_d_q.push_back(5);   exp_o_q.push_back(1'b0);
`ifdef SAMPLE_MAC_RELU_EN
        exp_d_q.push_back(0);   exp_o_q.push_back(1'b0);
`else
        exp_d_q.push_back(-10); exp_o_q.push_back(1'b0);
`endif
        exp_d_q.push_back(21);  exp_o_q.push_back(1'b0);
        exp_d_q.push_back(12);  exp_o_q.push_back(1'b0);
        issue_elem(16, 50, 1'b0);
        issue_elem(16, 50, 1'b1);
        issue_elem(0, -160, 1'b1);
        issue_elem(16, 320, 1'b1);
        issue_elem(64, 0, 1'b0);
        issue_elem(64, 0, 1'b0);
        issue_elem(64, 0, 1'b1);
        go_idle();
        wait_drain();
        check("b2b_no_stall", stall_cnt, 0);
        check("b2b_result_count", hs_cyc.size(), 4);
        for (int k = 0; k < 4 && k < hs_cyc.size() && k < last_cyc.size(); k++)
            check("b2b_latency", hs_cyc[k] - last_cyc[k], LAT + 1);

        // ---- randomized vectors against the reference ----
        rand_ready = 1'b1;
        for (int v = 0; v < 40; v++) begin
            int n = int'($urandom_range(1, 6));
            int b;
            if ($urandom_range(0, 1) == 1)
                b = int'($urandom_range(0, 4194304)) - 2097152;
            else
                b = int'($urandom_range(0, 131072)) - 65536;
            ps.delete();
            for (int k = 0; k < n; k++) ps.push_back(int'($urandom_range(0, 2047)) - 1024);
            ref_result(b, ps, d, o);
            exp_d_q.push_back(d);
            exp_o_q.push_back(o);
            issue_vec(b, ps);
            if ($urandom_range(0, 2) == 0) begin
                go_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        go_idle();
        @(negedge clk);
        rand_ready = 1'b0;
        res_ready  = 1'b1;
        wait_drain();

        check("final_queue_empty", exp_d_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
